mov_izquierda_seq: RTL

MOV_IZQUIERDA_SEQ -- requirements
Module: mov_izquierda_seq

---
 rtl/mov_izquierda_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mov_izquierda_seq.sv
// Sequential 2048-style left move over a 4x4 board, one row per cycle.
// Score accumulation is built only when MOV_IZQUIERDA_PUNTAJE_EN is defined.
module mov_izquierda_seq #(
    parameter int W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0][3:0][W-1:0]    matriz_entrada,
    output logic [3:0][3:0][W-1:0]    matriz_resultante,
    output logic                      mov,
    output logic [W-1:0]              puntaje,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, FILA, FIN} estado_t;
    typedef logic [3:0][W-1:0] fila_t;

    estado_t                 estado_q, estado_d;
    logic [1:0]              fila_q, fila_d;
    logic [3:0][3:0][W-1:0]  tablero_q, tablero_d;
    logic [3:0][3:0][W-1:0]  res_q, res_d;
    logic                    mov_acc_q, mov_acc_d;
    logic                    mov_q, mov_d;
    logic                    done_q, done_d;

    fila_t                   fila_in, fila_cmp, fila_mrg, fila_out;
    logic [2:0]              fusion;
    logic                    salta;
    logic                    fila_mov;

    function automatic fila_t compactar(input fila_t f);
        fila_t      r;
        logic [2:0] n;
        r = '0;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            if (f[i] != '0) begin
                r[n[1:0]] = f[i];
                n = n + 3'd1;
            end
        end
        return r;
    endfunction

    // Single row datapath: compact, merge pairs once each, compact again.
    always_comb begin
        fila_in  = tablero_q[fila_q];
        fila_cmp = compactar(fila_in);
        fila_mrg = fila_cmp;
        fusion   = '0;
        salta    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!salta && fila_cmp[i] != '0 && fila_cmp[i] == fila_cmp[i+1]) begin
                fila_mrg[i]   = fila_cmp[i] + fila_cmp[i];
                fila_mrg[i+1] = '0;
                fusion[i]     = 1'b1;
                salta         = 1'b1;
            end else begin
                salta = 1'b0;
            end
        end
        fila_out = compactar(fila_mrg);
        fila_mov = (fila_out != fila_in);
    end

    always_comb begin
        estado_d  = estado_q;
        fila_d    = fila_q;
        tablero_d = tablero_q;
        res_d     = res_q;
        mov_acc_d = mov_acc_q;
        mov_d     = mov_q;
        done_d    = 1'b0;
        case (estado_q)
            IDLE: begin
                if (start) begin
                    tablero_d = matriz_entrada;
                    fila_d    = 2'd0;
                    mov_acc_d = 1'b0;
                    estado_d  = FILA;
                end
            end
            FILA: begin
                tablero_d[fila_q] = fila_out;
                mov_acc_d         = mov_acc_q | fila_mov;
                fila_d            = fila_q + 2'd1;
                if (fila_q == 2'd3) begin
                    estado_d = FIN;
                end
            end
            FIN: begin
                // Results become visible only once the whole board is done.
                res_d    = tablero_q;
                mov_d    = mov_acc_q;
                done_d   = 1'b1;
                estado_d = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= IDLE;
            fila_q    <= '0;
            tablero_q <= '0;
            res_q     <= '0;
            mov_acc_q <= 1'b0;
            mov_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            fila_q    <= fila_d;
            tablero_q <= tablero_d;
            res_q     <= res_d;
            mov_acc_q <= mov_acc_d;
            mov_q     <= mov_d;
            done_q    <= done_d;
        end
    end

`ifdef MOV_IZQUIERDA_PUNTAJE_EN
    logic [W-1:0] fila_pts;
    logic [W-1:0] pts_acc_q, pts_acc_d;
    logic [W-1:0] puntaje_q, puntaje_d;

    always_comb begin
        fila_pts = '0;
        for (int i = 0; i < 3; i++) begin
            if (fusion[i]) begin
                fila_pts = fila_pts + fila_mrg[i];
            end
        end
    end

    always_comb begin
        pts_acc_d = pts_acc_q;
        puntaje_d = puntaje_q;
        case (estado_q)
            IDLE:    if (start) pts_acc_d = '0;
            FILA:    pts_acc_d = pts_acc_q + fila_pts;
            FIN:     puntaje_d = pts_acc_q;
            default: pts_acc_d = pts_acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pts_acc_q <= '0;
            puntaje_q <= '0;
        end else begin
            pts_acc_q <= pts_acc_d;
            puntaje_q <= puntaje_d;
        end
    end

    assign puntaje = puntaje_q;
`else
    assign puntaje = '0;
`endif

    assign matriz_resultante = res_q;
    assign mov               = mov_q;
    assign done              = done_q;
    assign busy              = (estado_q != IDLE);

endmodule
